tile_map_writer: RTL and testbench
==================================

# tile_map_writer

Writer side of the board display path: accepts tile updates from game logic over a valid/ready handshake, buffers them, and commits them to the live 16-tile board only while the VGA vertical sync is active, so a frame is never drawn half-updated. The tile-select logic reads the live board back by area code (1..16) to choose the tile image for each pixel. Runs on the VGA pixel clock (`clkdiv[1]`).

## Interface
- `DEPTH`, 4: update FIFO depth (power of two, ≥2).
- `TILE_W`, 4: tile code width; code = log2 of tile value, 0 = empty, 11 = 2048.
- `clk` in 1: VGA pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `upd_valid` in 1: update request.
- `upd_ready` out 1: block can accept an update this cycle.
- `upd_idx` in 4: tile index 0..15 (area code minus 1).
- `upd_val` in TILE_W: new tile code, stored unmodified.
- `vs` in 1: vertical sync from the VGA controller, active low.
- `rd_area` in 6: area code from the address decoder; 0 = background.
- `rd_code` out TILE_W: tile code for `rd_area`, registered.
- `frame_tick` out 1: one-cycle pulse on each `vs` falling edge.
- `pending` out log2(DEPTH)+1: FIFO occupancy.

## Operation
- Update is accepted on any cycle with `upd_valid && upd_ready`; `{upd_idx, upd_val}` is pushed into the FIFO.
- `upd_ready = !full && !rst`. A push while full is not possible; a pop in the same cycle does not reopen `upd_ready` until the next cycle.
- `vs` is registered once (`vs_q`); `frame_tick = vs_q && !vs`.
- Two-state FSM:
  - IDLE: `vs` high. No commits. Go to DRAIN when `vs` goes low.
  - DRAIN: `vs` low. Each cycle FIFO is non-empty, pop one entry and write `live[idx] <= val`. Return to IDLE when `vs` is high; any entries left wait for the next sync window.
- Push and pop in the same cycle are both allowed; `pending` is unchanged.
- Entries commit in acceptance order; repeated indices resolve last-wins.
- Read: `rd_area` 1..16 gives `rd_code = live[rd_area-1]`; 0 or 17..63 gives 0.
- A read and a commit to the same tile in the same cycle return the old value (read-before-write).
- Reset values: live board all 0, FIFO empty, `pending` 0, `rd_code` 0, `frame_tick` 0, `vs_q` 1, FSM IDLE, `upd_ready` 0 while `rst` is high.
- Reset during DRAIN discards all uncommitted entries; committed tiles are cleared to 0.

## Timing
- Accept to commit:
  - If `vs` is already low with an empty FIFO, the entry commits on the cycle after acceptance.
  - Otherwise it commits within DRAIN, in FIFO order.
- Commit rate: 1 entry/cycle. The sync window (≥2 lines) always drains a full FIFO.
- `rd_code` latency: 1 cycle from `rd_area`.
- `frame_tick` asserts 1 cycle after the `vs` falling edge.
- `pending` is registered and reflects pushes and pops of the previous edge.

## Structure
- Shared package `tile_pkg`: `TILE_W`, `N_TILES = 16`, `TILE_2048 = 11`, `AREA_BG = 0`, and update struct type `tile_upd_t {idx, val}`.
- One sub-module, `tile_upd_fifo`: synchronous FIFO parameterised by DEPTH with push, pop, full, empty and count.
- FSM, commit and read mux sit in the top.

## Test plan
- Reset then idle, `vs` high: `upd_ready` = 1 after reset; all `rd_area` 1..16 → `rd_code` 0; `pending` 0.
- Push (idx 5, val 1) with `vs` high: `pending` = 1; `rd_area` 6 → 0 until `vs` falls; one cycle after entering DRAIN, `rd_area` 6 → 1.
- Push 4 entries with `vs` high: `upd_ready` = 0 and a 5th push is refused. Drop `vs`: four commits on 4 consecutive cycles and `pending` counts 4→0.
- Push (3, 2) then (3, 11) and open the window: `rd_area` 4 → 11 (last-wins).
- Push during DRAIN with FIFO at 1 entry: `pending` stays 1. Raise `vs` with 2 entries left: no commits until the next `vs` fall. Assert `frame_tick` once per fall.
- Assert `rst` mid-DRAIN with 3 pending: `pending` 0, all tiles read 0, `upd_ready` 0 during reset and 1 after.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared types and constants for the board tile writer path.
package tile_pkg;

  localparam int unsigned TILE_W    = 4;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned N_TILES   = 16;
  localparam int unsigned TILE_2048 = 11;
  localparam int unsigned AREA_BG   = 0;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [TILE_W-1:0] val;
  } tile_upd_t;

endpackage

// File: rtl/tile_map_writer_if.sv
// Tile update valid/ready handshake from game logic to the board writer.
interface tile_map_writer_if
  import tile_pkg::*;
#(
  parameter int unsigned TILE_W = 4
);

  logic              upd_valid;
  logic              upd_ready;
  logic [IDX_W-1:0]  upd_idx;
  logic [TILE_W-1:0] upd_val;

  modport master (output upd_valid, output upd_idx, output upd_val, input upd_ready);
  modport slave  (input upd_valid, input upd_idx, input upd_val, output upd_ready);

endinterface

// File: rtl/tile_upd_fifo.sv
// Synchronous FIFO buffering tile updates until the next vertical sync window.
module tile_upd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            wr_data,
  input  logic                     pop,
  output logic [DW-1:0]            rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/tile_map_writer.sv
// Buffers tile updates and commits them to the live board only during vertical sync.
module tile_map_writer
  import tile_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TILE_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  tile_map_writer_if.slave       upd,
  input  logic                   vs,
  input  logic [5:0]             rd_area,
  output logic [TILE_W-1:0]      rd_code,
  output logic                   frame_tick,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int unsigned ENTRY_W = IDX_W + TILE_W;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_DRAIN = 1'b1;

  logic                state_q, state_d;
  logic                vs_q, vs_d;
  logic                frame_tick_q, frame_tick_d;
  logic [TILE_W-1:0]   rd_code_q, rd_code_d;
  logic [TILE_W-1:0]   live_q [N_TILES];
  logic [TILE_W-1:0]   live_d [N_TILES];

  logic                push, pop, full, empty;
  logic [ENTRY_W-1:0]  wr_data, rd_data;
  logic [IDX_W-1:0]    commit_idx;
  logic [5:0]          area_m1;

  assign upd.upd_ready = !full && !rst;
  assign push          = upd.upd_valid && upd.upd_ready;
  assign wr_data       = {upd.upd_idx, upd.upd_val};
  assign commit_idx    = rd_data[ENTRY_W-1 -: IDX_W];
  assign area_m1       = rd_area - 6'd1;

  tile_upd_fifo #(
    .DEPTH (DEPTH),
    .DW    (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (pending)
  );

  // Pop is also gated by the live vs so commits stop on the very edge vs rises.
  always_comb begin
    state_d      = vs ? ST_IDLE : ST_DRAIN;
    pop          = (state_q == ST_DRAIN) && !vs && !empty;
    vs_d         = vs;
    frame_tick_d = vs_q && !vs;
    live_d       = live_q;
    if (pop) begin
      live_d[commit_idx] = rd_data[TILE_W-1:0];
    end
    rd_code_d = '0;
    if ((rd_area != 6'(AREA_BG)) && (rd_area <= 6'(N_TILES))) begin
      rd_code_d = live_q[area_m1[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vs_q         <= 1'b1;
      frame_tick_q <= 1'b0;
      rd_code_q    <= '0;
      for (int unsigned i = 0; i < N_TILES; i++) begin
        live_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      vs_q         <= vs_d;
      frame_tick_q <= frame_tick_d;
      rd_code_q    <= rd_code_d;
      live_q       <= live_d;
    end
  end

  assign rd_code    = rd_code_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_tile_map_writer.sv
// Directed bench for tile_map_writer with a queue scoreboard of pending commits.
module tb_tile_map_writer;
  import tile_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = 4;

  logic          clk;
  logic          rst;
  logic          vs;
  logic [5:0]    rd_area;
  logic [TW-1:0] rd_code;
  logic          frame_tick;
  logic [2:0]    pending;

  tile_map_writer_if #(.TILE_W(TW)) upd_bus ();

  tile_map_writer #(
    .DEPTH  (DEPTH),
    .TILE_W (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .upd        (upd_bus),
    .vs         (vs),
    .rd_area    (rd_area),
    .rd_code    (rd_code),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Scoreboard: accepted updates queue here and retire in order during the sync window.
  tile_upd_t     exp_q [$];
  logic [TW-1:0] m_live [N_TILES];
  logic          m_vsq, m_drain, m_tick;
  logic [TW-1:0] m_rd;

  always @(posedge clk) begin : model
    tile_upd_t e;
    logic      acc;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < N_TILES; i++) m_live[i] = '0;
      m_vsq   = 1'b1;
      m_drain = 1'b0;
      m_tick  = 1'b0;
      m_rd    = '0;
    end else begin
      acc  = upd_bus.upd_valid && (exp_q.size() < DEPTH);
      m_rd = (rd_area >= 1 && rd_area <= 16) ? m_live[int'(rd_area) - 1] : '0;
      if (m_drain && !vs && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_live[e.idx] = e.val;
      end
      if (acc) begin
        e.idx = upd_bus.upd_idx;
        e.val = upd_bus.upd_val;
        exp_q.push_back(e);
      end
      m_tick  = m_vsq && !vs;
      m_vsq   = vs;
      m_drain = !vs;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ready();
    chk("upd_ready", 32'(upd_bus.upd_ready), 32'(!rst && exp_q.size() < DEPTH));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("pending_sb", 32'(pending), 32'(exp_q.size()));
    chk("frame_tick_sb", 32'(frame_tick), 32'(m_tick));
    chk("rd_code_sb", 32'(rd_code), 32'(m_rd));
  endtask

  task automatic push(input logic [3:0] idx, input logic [TW-1:0] val);
    upd_bus.upd_valid = 1'b1;
    upd_bus.upd_idx   = idx;
    upd_bus.upd_val   = val;
    tick();
    upd_bus.upd_valid = 1'b0;
  endtask

  task automatic rd(input int area, input int exp);
    rd_area = 6'(area);
    tick();
    chk($sformatf("rd_area_%0d", area), 32'(rd_code), 32'(exp));
  endtask

  initial begin
    int ticks;
    rst = 1'b1;
    vs = 1'b1;
    rd_area = '0;
    upd_bus.upd_valid = 1'b0;
    upd_bus.upd_idx = '0;
    upd_bus.upd_val = '0;

    // reset and idle
    tick();
    tick();
    chk("ready_in_reset", 32'(upd_bus.upd_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 32'(upd_bus.upd_ready), 32'd1);
    chk("pending_reset", 32'(pending), 32'd0);
    chk("frame_tick_reset", 32'(frame_tick), 32'd0);
    for (int a = 1; a <= 17; a++) rd(a, 0);

    // single update committed only once vs falls
    push(4'd5, 4'd1);
    chk("pending_one", 32'(pending), 32'd1);
    rd(6, 0);
    rd(6, 0);
    vs = 1'b0;
    tick();
    chk("tick_first_fall", 32'(frame_tick), 32'd1);
    tick();
    tick();
    chk("rd6_after_drain", 32'(rd_code), 32'd1);
    chk("pending_drained", 32'(pending), 32'd0);
    vs = 1'b1;
    tick();
    tick();

    // fill FIFO, refuse a fifth, then drain one per cycle
    push(4'd0, 4'd1);
    push(4'd1, 4'd2);
    push(4'd2, 4'd3);
    push(4'd3, 4'd4);
    chk("ready_full", 32'(upd_bus.upd_ready), 32'd0);
    chk("pending_full", 32'(pending), 32'd4);
    push(4'd7, 4'd9);
    chk("pending_refused", 32'(pending), 32'd4);
    chk_ready();
    vs = 1'b0;
    tick();
    chk("pending_drain0", 32'(pending), 32'd4);
    for (int k = 3; k >= 0; k--) begin
      tick();
      chk($sformatf("pending_drain_%0d", k), 32'(pending), 32'(k));
    end
    rd(1, 1);
    rd(2, 2);
    rd(3, 3);
    rd(4, 4);
    rd(8, 0);

    // last-wins on a repeated index
    vs = 1'b1;
    tick();
    push(4'd3, 4'd2);
    push(4'd3, TW'(TILE_2048));
    vs = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rd(4, TILE_2048);

    // push during drain keeps one entry in flight
    push(4'd9, 4'd6);
    chk("pending_stream_0", 32'(pending), 32'd1);
    for (int k = 0; k < 3; k++) begin
      push(4'(10 + k), 4'(7 + k));
      chk($sformatf("pending_stream_%0d", k + 1), 32'(pending), 32'd1);
    end
    tick();
    chk("pending_stream_end", 32'(pending), 32'd0);
    rd(13, 9);

    // entries held across a closed window, one tick per fall
    vs = 1'b1;
    tick();
    push(4'd14, 4'd5);
    push(4'd15, 4'd8);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pending_hold", 32'(pending), 32'd2);
    end
    rd(16, 0);
    vs = 1'b0;
    ticks = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (frame_tick) ticks++;
    end
    chk("tick_count_per_fall", 32'(ticks), 32'd1);
    chk("pending_window_done", 32'(pending), 32'd0);
    rd(15, 5);
    rd(16, 8);

    // reset mid-drain discards queue and clears board
    vs = 1'b1;
    tick();
    push(4'd10, 4'd5);
    push(4'd11, 4'd6);
    push(4'd12, 4'd7);
    vs = 1'b0;
    tick();
    chk("pending_pre_rst", 32'(pending), 32'd3);
    rst = 1'b1;
    #1;
    chk("ready_mid_rst", 32'(upd_bus.upd_ready), 32'd0);
    tick();
    chk("pending_rst", 32'(pending), 32'd0);
    rst = 1'b0;
    vs = 1'b1;
    #1;
    chk("ready_post_rst", 32'(upd_bus.upd_ready), 32'd1);
    for (int a = 1; a <= 16; a++) rd(a, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
